echo_say_arbiter: RTL and testbench
===================================

Name: echo_say_arbiter

Overview:
- Round-robin arbiter that shares one guarded `say` method (ENA/RDY plus data) among N client modules.
- Sits between client Echo-style producers and the single `say` port of an Echo instance, which internally enqueues into its Fifo1.
- Grants one client at a time and holds the grant for a bounded burst.
- Counts completed transfers and flags protocol violations.

Parameters:
- N, 4, number of requesting clients (2..8).
- W, 32, width of the `say` payload.
- MAX_BURST, 4, maximum consecutive transfers per grant (1..15).

Ports:
- CLK  in  1  clock; all state updates on its rising edge.
- nRST  in  1  asynchronous, active-low reset.
- cli_want  in  N  bit i set: client i has data pending and requests ownership.
- cli_say__ENA  in  N  client i fires its say method this cycle.
- cli_say_v  in  N*W  client i payload, in bits [i*W +: W].
- cli_say__RDY  out  N  client i may fire say this cycle.
- say__ENA  out  1  downstream say method enable.
- say_v  out  W  downstream say payload.
- say__RDY  in  1  downstream say guard; is `fifo$enq__RDY` of the Echo instance.
- grant  out  N  one-hot current owner; all zero when idle.
- xfer_count  out  32  total completed downstream transfers.
- proto_err  out  1  sticky: a client fired ENA without RDY.

Behaviour:
- Reset (async, nRST=0):
  - state=IDLE, owner=0, rr_ptr=0, burst_cnt=0.
  - xfer_count=0, proto_err=0.
  - All outputs low/zero: grant=0, cli_say__RDY=0, say__ENA=0, say_v=0.
  - Reset asserted mid-burst aborts the grant immediately; no transfer completes in that cycle.
- State IDLE:
  - grant=0, cli_say__RDY=0, say__ENA=0.
  - If cli_want is non-zero, select the first set bit scanning from index rr_ptr upward, wrapping modulo N.
  - On the next edge: owner=selection, burst_cnt=0, state=OWNED.
  - Arbitration latency: exactly 1 cycle from want to grant.
- State OWNED:
  - grant = one-hot(owner).
  - cli_say__RDY[owner] = say__RDY; every other bit of cli_say__RDY is 0.
  - say__ENA = cli_say__ENA[owner] & say__RDY.
  - say_v = owner's payload slice; payload muxing is purely combinational.
- Transfer definition: a cycle with say__ENA=1. On a transfer:
  - xfer_count increments by 1, wrapping 2^32-1 -> 0.
  - burst_cnt increments by 1.
- Release from OWNED (evaluated at the clock edge):
  - (a) a transfer occurs with burst_cnt == MAX_BURST-1, or
  - (b) cli_want[owner] == 0.
  - On release: state=IDLE, rr_ptr=(owner+1) mod N, burst_cnt=0.
  - Both conditions in the same cycle give a single release.
  - A released owner always incurs one IDLE bubble cycle before the next grant.
- Downstream stall: say__RDY=0 holds OWNED indefinitely while want stays high. burst_cnt does not advance.
- Protocol error: any cli_say__ENA[i]=1 while cli_say__RDY[i]=0.
  - Sets proto_err=1 on the next edge; it stays set until reset.
  - The offending enable is ignored and not forwarded.
- Simultaneous events:
  - Non-owner ENA in the same cycle as an owner transfer: the owner transfers, and proto_err sets.
  - want deasserted in the same cycle as a transfer: the transfer counts, then release.

Test Plan:
- Single client, N=4, MAX_BURST=4: cli_want=0001, six payloads 0x10..0x15 with say__RDY=1.
  - Grant after 1 cycle. Transfers 0x10..0x13, then an IDLE bubble, re-grant to client 0, then 0x14, 0x15.
  - xfer_count=6.
- Round-robin fairness: cli_want=1111 held, every client fires on each RDY.
  - Grant order is 0,1,2,3,0 with 4 transfers each.
  - Each handoff has exactly one IDLE cycle.
- Early release: client 2 owns and transfers 0xAB once, then drops want.
  - Release after 1 transfer; rr_ptr=3.
  - With cli_want=0101 pending, the next grant goes to client 0 (scan 3 -> 0).
- Backpressure: owner firing, say__RDY=0 for 5 cycles.
  - cli_say__RDY[owner]=0 and say__ENA=0 throughout; xfer_count unchanged; grant held.
  - Transfers resume when say__RDY returns to 1.
- Protocol violation: client 3 asserts ENA while client 1 owns.
  - proto_err=1 from the next cycle and sticky.
  - say_v never shows client 3 data; client 1 transfer unaffected.
- Async reset mid-burst: drop nRST after 2 of 4 transfers, between clock edges.
  - grant=0, say__ENA=0, xfer_count=0 immediately, without waiting for an edge.
  - After release: 1-cycle arbitration starting from client 0.

Source files
------------

// File: rtl/echo_say_arbiter.sv
// Round-robin arbiter sharing one guarded `say` method (ENA/RDY + payload)
// among N clients in front of a single Echo `say` port.
//
// Ports:
//   CLK, nRST      clock (rising edge) and asynchronous active-low reset
//   cli_want       per-client ownership request
//   cli_say__ENA   per-client say enable
//   cli_say_v      per-client payload, client i in bits [i*W +: W]
//   cli_say__RDY   per-client say guard (only the owner can see RDY)
//   say__ENA       downstream say enable
//   say_v          downstream say payload
//   say__RDY       downstream say guard (Echo fifo enq ready)
//   grant          one-hot current owner, zero when idle
//   xfer_count     completed downstream transfers (wraps)
//   proto_err      sticky flag: some client fired ENA without RDY
module echo_say_arbiter #(
    parameter int unsigned N         = 4,
    parameter int unsigned W         = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [N-1:0]     cli_want,
    input  logic [N-1:0]     cli_say__ENA,
    input  logic [N*W-1:0]   cli_say_v,
    output logic [N-1:0]     cli_say__RDY,
    output logic             say__ENA,
    output logic [W-1:0]     say_v,
    input  logic             say__RDY,
    output logic [N-1:0]     grant,
    output logic [31:0]      xfer_count,
    output logic             proto_err
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned BW = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic [31:0]     count_d;
    logic            perr_d;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   idx;

    // First requester at or after rr_ptr, wrapping; descending loop so the
    // closest index to rr_ptr is written last and wins.
    always_comb begin : scan
        pick = rr_ptr_q;
        idx  = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            idx = IW'((32'(rr_ptr_q) + 32'(k)) % N);
            if (cli_want[idx]) begin
                pick = idx;
            end
        end
    end

    // Owner-routed guard/enable/payload mux, then next-state logic.
    always_comb begin : fsm_comb
        grant        = '0;
        cli_say__RDY = '0;
        say__ENA     = 1'b0;
        say_v        = '0;
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        burst_d      = burst_q;
        count_d      = xfer_count;

        if (state_q == OWNED) begin
            grant[owner_q]        = 1'b1;
            cli_say__RDY[owner_q] = say__RDY;
            say__ENA              = cli_say__ENA[owner_q] & say__RDY;
            say_v                 = cli_say_v[32'(owner_q) * W +: W];
        end

        // Any enable not matched by its guard is a violation and is dropped.
        perr_d = proto_err | (|(cli_say__ENA & ~cli_say__RDY));

        if (say__ENA) begin
            count_d = xfer_count + 32'd1;
        end

        case (state_q)
            IDLE: begin
                if (|cli_want) begin
                    owner_d = pick;
                    burst_d = '0;
                    state_d = OWNED;
                end
            end
            OWNED: begin
                if (say__ENA) begin
                    burst_d = burst_q + BW'(1);
                end
                // Burst exhausted or owner lost interest: single release,
                // always followed by one idle bubble.
                if ((say__ENA && (burst_q == BW'(MAX_BURST - 1))) || !cli_want[owner_q]) begin
                    state_d  = IDLE;
                    burst_d  = '0;
                    rr_ptr_d = (owner_q == IW'(N - 1)) ? '0 : owner_q + IW'(1);
                end
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            burst_q    <= '0;
            xfer_count <= '0;
            proto_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            burst_q    <= burst_d;
            xfer_count <= count_d;
            proto_err  <= perr_d;
        end
    end

endmodule

// File: tb/tb_echo_say_arbiter.sv
// Self-checking bench for echo_say_arbiter: randomized clients against a
// transaction-level reference model, with a scoreboard monitor.
module tb_echo_say_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 32;
    localparam int unsigned MB = 4;

    logic             CLK;
    logic             nRST;
    logic [N-1:0]     cli_want;
    logic [N-1:0]     cli_say__ENA;
    logic [N*W-1:0]   cli_say_v;
    logic [N-1:0]     cli_say__RDY;
    logic             say__ENA;
    logic [W-1:0]     say_v;
    logic             say__RDY;
    logic [N-1:0]     grant;
    logic [31:0]      xfer_count;
    logic             proto_err;

    echo_say_arbiter #(.N(N), .W(W), .MAX_BURST(MB)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .cli_want     (cli_want),
        .cli_say__ENA (cli_say__ENA),
        .cli_say_v    (cli_say_v),
        .cli_say__RDY (cli_say__RDY),
        .say__ENA     (say__ENA),
        .say_v        (say_v),
        .say__RDY     (say__RDY),
        .grant        (grant),
        .xfer_count   (xfer_count),
        .proto_err    (proto_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [N-1:0] grant;
        logic [N-1:0] rdy;
        logic         ena;
        logic         perr;
        logic [31:0]  cnt;
    } cyc_t;

    cyc_t         cyc_q[$];
    logic [W-1:0] xfer_q[$];
    int           errors = 0;
    int           checks = 0;

    // Reference model: who owns the port (-1 = nobody), where the next
    // search starts, transfers in this grant, totals and the sticky flag.
    int           own   = -1;
    int           ptr   = 0;
    int           burst = 0;
    logic [31:0]  cnt   = '0;
    logic         perr  = 1'b0;
    int           sent  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle expectations plus in-order payload scoreboard.
    initial begin : monitor
        cyc_t e;
        forever begin
            @(negedge CLK);
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                chk("grant", 64'(grant), 64'(e.grant));
                chk("cli_rdy", 64'(cli_say__RDY), 64'(e.rdy));
                chk("say_ena", 64'(say__ENA), 64'(e.ena));
                chk("proto_err", 64'(proto_err), 64'(e.perr));
                chk("xfer_count", 64'(xfer_count), 64'(e.cnt));
            end
            if (say__ENA === 1'b1) begin
                if (xfer_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_xfer: got say_v %0h expected no transfer", say_v);
                end else begin
                    chk("say_v", 64'(say_v), 64'(xfer_q.pop_front()));
                end
            end
        end
    end

    // One clock of stimulus. mode 0: single client 0 sending 0x10..0x15;
    // 1: random well-behaved; 2: heavy backpressure; 3: random with stray enables.
    task automatic step(input int mode);
        logic [N-1:0] w, e, eg, er;
        logic         sr, ee;
        logic [W-1:0] p [N];
        cyc_t         c;
        @(posedge CLK);
        #1;
        for (int i = 0; i < int'(N); i++) p[i] = $urandom();
        if (mode == 0) begin
            w    = (sent < 6) ? N'(1) : '0;
            sr   = 1'b1;
            p[0] = 32'h10 + 32'(sent);
        end else begin
            for (int i = 0; i < int'(N); i++) w[i] = ($urandom_range(0, 99) < 80);
            sr = (mode == 2) ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 85);
        end
        eg = '0;
        if (own >= 0) eg[own] = 1'b1;
        er = sr ? eg : '0;
        e  = '0;
        for (int i = 0; i < int'(N); i++)
            e[i] = er[i] && w[i] && (mode == 0 || $urandom_range(0, 99) < 70);
        if (mode == 3 && $urandom_range(0, 99) < 8) e[$urandom_range(0, N - 1)] = 1'b1;
        if (mode == 2 && own >= 0 && w[own] && $urandom_range(0, 99) < 10) e[own] = 1'b1;

        cli_want     = w;
        cli_say__ENA = e;
        say__RDY     = sr;
        for (int i = 0; i < int'(N); i++) cli_say_v[i*W +: W] = p[i];

        ee     = (own >= 0) && e[own] && sr;
        c.grant = eg;
        c.rdy   = er;
        c.ena   = ee;
        c.perr  = perr;
        c.cnt   = cnt;
        cyc_q.push_back(c);
        if (ee) begin
            xfer_q.push_back(p[own]);
            sent++;
        end

        if ((e & ~er) != '0) perr = 1'b1;
        if (own < 0) begin
            if (w != '0) begin
                for (int k = 0; k < int'(N); k++) begin
                    int j;
                    j = (ptr + k) % int'(N);
                    if (w[j]) begin
                        own   = j;
                        burst = 0;
                        break;
                    end
                end
            end
        end else begin
            if (ee) begin
                cnt   = cnt + 32'd1;
                burst = burst + 1;
            end
            if ((ee && burst == int'(MB)) || !w[own]) begin
                ptr   = (own + 1) % int'(N);
                own   = -1;
                burst = 0;
            end
        end
    endtask

    // Reset asserted between clock edges; its effect must be immediate.
    task automatic rst_mid();
        @(negedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_say_ena", 64'(say__ENA), 64'd0);
        chk("rst_xfer_count", 64'(xfer_count), 64'd0);
        chk("rst_cli_rdy", 64'(cli_say__RDY), 64'd0);
        chk("rst_say_v", 64'(say_v), 64'd0);
        chk("rst_proto_err", 64'(proto_err), 64'd0);
        chk("pending_xfers", 64'(xfer_q.size()), 64'd0);
        xfer_q.delete();
        cyc_q.delete();
        own          = -1;
        ptr          = 0;
        burst        = 0;
        cnt          = '0;
        perr         = 1'b0;
        sent         = 0;
        cli_want     = '0;
        cli_say__ENA = '0;
        say__RDY     = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin : driver
        nRST         = 1'b0;
        cli_want     = '0;
        cli_say__ENA = '0;
        cli_say_v    = '0;
        say__RDY     = 1'b0;
        rst_mid();
        repeat (14) step(0);
        rst_mid();
        repeat (400) step(1);
        rst_mid();
        repeat (300) step(2);
        rst_mid();
        repeat (300) step(3);
        rst_mid();
        repeat (200) step(1);
        @(negedge CLK);
        #1;
        chk("final_pending_xfers", 64'(xfer_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
